aes_key_sched_seq: RTL and testbench
====================================

Name: aes_key_sched_seq

Overview:
- Iterative AES-128 forward key scheduler for the encryption direction.
- Accepts a 128-bit cipher key over a valid/ready handshake and streams round keys 0..10, one per handshake beat, with output backpressure.
- Performs the S-box lookups through four instances of a forward S-box; the decryption path's inverse S-box is not used here.
- Also latches the round-10 key, which the decryption datapath uses as its starting key.

Parameters:
- EMIT_RK0, default 1: 1 means round key 0 (the raw input key) is emitted as the first beat; 0 means the stream starts at round 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_vld  in  1  key_in is valid.
- key_rdy  out  1  scheduler can accept a key; equals (state==IDLE).
- key_in  in  128  cipher key; w0=key_in[127:96] ... w3=key_in[31:0].
- rk_vld  out  1  rk and rk_idx are valid.
- rk_rdy  in  1  consumer accepts the current round key.
- rk  out  128  round key, same word order as key_in.
- rk_idx  out  4  round number of rk, 0..10.
- done  out  1  one-cycle pulse after the round-10 beat is accepted.
- last_key  out  128  round-10 key of the most recently completed schedule.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; rk_vld=0, rk=0, rk_idx=0, done=0, last_key=0, rcon=8'h01.
  - Reset mid-schedule abandons it; last_key is also cleared.
- States:
  - IDLE: key_rdy=1. An edge with key_vld sampled high moves to RUN.
  - RUN: key_rdy=0. Moves back to IDLE when the round-10 beat is accepted.
- Accept edge (IDLE with key_vld=1):
  - EMIT_RK0=1: rk<=key_in, rk_idx<=0, rcon<=01.
  - EMIT_RK0=0: rk<=next(key_in,01), rk_idx<=1, rcon<=02.
  - In both cases rk_vld<=1.
- Beat edge (RUN with rk_vld & rk_rdy):
  - If rk_idx<10: rk<=next(rk,rcon), rk_idx<=rk_idx+1, rcon<=xtime(rcon).
  - If rk_idx==10: rk_vld<=0, done<=1, last_key<=rk, state<=IDLE. rk and rk_idx hold their values.
- Stall: with rk_vld=1 and rk_rdy=0, rk, rk_idx and rcon hold exactly; rk_vld stays 1.
- done is 0 on every edge that is not the completion edge.
- next(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}; SubWord applies the forward S-box to each byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
  - Sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency (rk_rdy tied 1): first rk_vld on the cycle after accept. Beats are contiguous: 11 beats for EMIT_RK0=1, 10 for EMIT_RK0=0. done is high the cycle after the last beat.
- Back-to-back: key_rdy=1 in the same cycle done=1, so a new key may be accepted then. done and last_key are unaffected by the new accept.
- key_vld while in RUN is ignored; no queuing.
- key_in is sampled only on the accept edge; later changes have no effect.
- rk_idx never exceeds 10. There is no wrap-around; the schedule ends in IDLE.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_word_t (32 bits) and aes_key_t (128 bits)
  - constant AES_NR=10 and constant RCON_INIT=8'h01
  - function xtime
  - enum ks_state_t {IDLE, RUN}
- Sub-module aes_fwd_sbox(a[7:0], d[7:0]): combinational FIPS-197 forward S-box table, instantiated 4x for SubWord.
  - Unit-tested so that inverse_sbox(fwd_sbox(x))==x for all 256 values of x.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_rdy=1, EMIT_RK0=1:
  - rk0=key_in.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 contiguous beats; done one cycle after the last beat; last_key=rk10.
- All-zero key:
  - rk1=62636363626363636263636362636363.
  - rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Randomized rk_rdy with the A.1 key: rk, rk_idx and rk_vld hold during stalls.
  - Beat sequence is identical to the unstalled run; key_vld pulses during RUN are ignored.
- rst pulsed at beat 5:
  - Next cycle rk_vld=0, key_rdy=1, last_key=0.
  - A fresh A.1 key then yields the correct rk1 (rcon restarted at 01).
- Back-to-back:
  - Zero key accepted in the done cycle of an A.1 run: last_key=d014f9a8...0ca6 while the new stream starts with rk_idx=0.
- EMIT_RK0=0 build:
  - First beat rk_idx=1, rk=a0fafe17...7605; exactly 10 beats, then done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key scheduler.
package aes_pkg;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    localparam logic [3:0] AES_NR    = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {IDLE, RUN} ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_fwd_sbox.sv
// Combinational FIPS-197 forward S-box lookup.
module aes_fwd_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    // Entry 0 sits in the most significant byte, so ~a selects the slot.
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign d = TBL[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128 forward key schedule, one round key per beat.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int EMIT_RK0 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_vld,
    output logic         key_rdy,
    input  logic [127:0] key_in,
    output logic         rk_vld,
    input  logic         rk_rdy,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         done,
    output logic [127:0] last_key
);
    ks_state_t state, state_nxt;
    logic [7:0] rcon, rc_sel;
    aes_key_t   src, nxt;
    aes_word_t  rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    logic       accept, beat, last_beat;

    assign accept    = (state == IDLE) && key_vld;
    assign beat      = (state == RUN) && rk_vld && rk_rdy;
    assign last_beat = (rk_idx == AES_NR);

    // In IDLE the round function runs on the incoming key (EMIT_RK0=0 case).
    assign src    = (state == IDLE) ? key_in : rk;
    assign rc_sel = (state == IDLE) ? RCON_INIT : rcon;
    assign rot    = {src[23:0], src[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_fwd_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .d (sub[8*i +: 8])
        );
    end

    assign t   = sub ^ {rc_sel, 24'h0};
    assign n0  = src[127:96] ^ t;
    assign n1  = src[95:64] ^ n0;
    assign n2  = src[63:32] ^ n1;
    assign n3  = src[31:0] ^ n2;
    assign nxt = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (key_vld) state_nxt = RUN;
            RUN:  if (beat && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_rdy = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_vld   <= 1'b0;
            rk       <= '0;
            rk_idx   <= '0;
            done     <= 1'b0;
            last_key <= '0;
            rcon     <= RCON_INIT;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rk_vld <= 1'b1;
                if (EMIT_RK0 != 0) begin
                    rk     <= key_in;
                    rk_idx <= 4'd0;
                    rcon   <= RCON_INIT;
                end else begin
                    rk     <= nxt;
                    rk_idx <= 4'd1;
                    rcon   <= xtime(RCON_INIT);
                end
            end else if (beat) begin
                if (last_beat) begin
                    rk_vld   <= 1'b0;
                    done     <= 1'b1;
                    last_key <= rk;
                end else begin
                    rk     <= nxt;
                    rk_idx <= rk_idx + 4'd1;
                    rcon   <= xtime(rcon);
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench: GF(2^8)-derived key expansion model vs both builds.
module tb_aes_key_sched_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, key_vld, key_rdy, rk_vld, rk_rdy, done;
    logic [127:0] key_in, rk, last_key;
    logic [3:0]   rk_idx;
    logic         key_vld0, key_rdy0, rk_vld0, rk_rdy0, done0;
    logic [127:0] key_in0, rk0, last_key0;
    logic [3:0]   rk_idx0;
    logic [7:0]   sb_a, sb_d;

    aes_key_sched_seq #(.EMIT_RK0(1)) dut (
        .clk(clk), .rst(rst), .key_vld(key_vld), .key_rdy(key_rdy),
        .key_in(key_in), .rk_vld(rk_vld), .rk_rdy(rk_rdy), .rk(rk),
        .rk_idx(rk_idx), .done(done), .last_key(last_key)
    );

    aes_key_sched_seq #(.EMIT_RK0(0)) dut0 (
        .clk(clk), .rst(rst), .key_vld(key_vld0), .key_rdy(key_rdy0),
        .key_in(key_in0), .rk_vld(rk_vld0), .rk_rdy(rk_rdy0), .rk(rk0),
        .rk_idx(rk_idx0), .done(done0), .last_key(last_key0)
    );

    aes_fwd_sbox u_sb (.a(sb_a), .d(sb_d));

    localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int vectors = 0;
    int errors  = 0;
    logic [7:0]   sbm [256];
    logic [7:0]   ism [256];
    logic [127:0] exp_ks [11];
    logic [127:0] got [11];

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine transform.
    task automatic build_sbox();
        logic [7:0] p, s;
        for (int x = 0; x < 256; x++) begin
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
            if (x == 0) p = 8'h00;
            s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]}
                  ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
            sbm[x] = s;
            ism[s] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbm[tmp[23:16]], sbm[tmp[15:8]],
                       sbm[tmp[7:0]], sbm[tmp[31:24]]};
                tmp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            exp_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic accept(input logic [127:0] key);
        int n = 0;
        while (key_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_rdy", key_rdy, 1);
        key_in  = key;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        key_in  = {4{$urandom()}};
    endtask

    task automatic stream(input logic [127:0] key, input int stall_pct,
                          input bit pulse, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        expand(key);
        while (idx <= 10 && cyc < 400) begin
            check("rk_vld", rk_vld, 1);
            check("rk_idx", rk_idx, idx);
            check("rk", rk, exp_ks[idx]);
            check("done_low", done, 0);
            check("key_rdy_run", key_rdy, 0);
            got[idx] = rk;
            if (idx == abort_at) begin
                key_vld = 1'b0;
                return;
            end
            rdy     = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            rk_rdy  = rdy;
            key_vld = pulse && ($urandom_range(1) == 1);
            key_in  = {4{$urandom()}};
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        key_vld = 1'b0;
        rk_rdy  = 1'b1;
        check("stream_bound", cyc < 400, 1);
        if (stall_pct == 0) check("contiguous", cyc, 11);
        check("done", done, 1);
        check("rk_vld_end", rk_vld, 0);
        check("last_key", last_key, exp_ks[10]);
        check("key_rdy_done", key_rdy, 1);
        check("rk_hold", rk, exp_ks[10]);
        check("rk_idx_hold", rk_idx, 10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        build_sbox();
        rst = 1'b1; key_vld = 1'b0; rk_rdy = 1'b1; key_in = '0;
        key_vld0 = 1'b0; rk_rdy0 = 1'b1; key_in0 = '0; sb_a = '0;
        repeat (2) @(negedge clk);
        check("rst_rk_vld", rk_vld, 0);
        check("rst_rk", rk, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_done", done, 0);
        check("rst_last_key", last_key, 0);
        check("rst_key_rdy", key_rdy, 1);
        check("rst_key_rdy0", key_rdy0, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int x = 0; x < 256; x++) begin
            sb_a = 8'(x);
            #1;
            check("sbox_inv", ism[sb_d], x);
        end
        @(negedge clk);

        accept(A1_KEY);
        stream(A1_KEY, 0, 0, -1);
        check("a1_rk0", got[0], A1_KEY);
        check("a1_rk1", got[1], A1_RK1);
        check("a1_rk10", got[10], A1_RK10);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        accept('0);
        stream('0, 0, 0, -1);
        check("zero_rk1", got[1], Z_RK1);
        check("zero_rk10", got[10], Z_RK10);

        accept(A1_KEY);
        stream(A1_KEY, 40, 1, -1);
        check("bp_rk1", got[1], A1_RK1);
        check("bp_rk10", got[10], A1_RK10);

        accept(A1_KEY);
        stream(A1_KEY, 30, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rk_vld", rk_vld, 0);
        check("mid_rst_key_rdy", key_rdy, 1);
        check("mid_rst_last_key", last_key, 0);
        check("mid_rst_done", done, 0);
        accept(A1_KEY);
        stream(A1_KEY, 0, 0, -1);
        check("post_rst_rk1", got[1], A1_RK1);

        accept(A1_KEY);
        stream(A1_KEY, 0, 0, -1);
        accept('0);
        check("b2b_done", done, 0);
        check("b2b_last_key", last_key, A1_RK10);
        check("b2b_rk_idx", rk_idx, 0);
        check("b2b_rk", rk, 0);
        stream('0, 0, 0, -1);
        check("b2b_zero_rk10", got[10], Z_RK10);

        for (int k = 0; k < 4; k++) begin
            logic [127:0] rkey;
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            accept(rkey);
            stream(rkey, (k == 0) ? 0 : 25, 1, -1);
        end

        expand(A1_KEY);
        key_in0  = A1_KEY;
        key_vld0 = 1'b1;
        @(negedge clk);
        key_vld0 = 1'b0;
        key_in0  = {4{$urandom()}};
        check("emit0_first_rk", rk0, A1_RK1);
        n = 0;
        while (rk_vld0 === 1'b1 && n < 20) begin
            check("emit0_rk_idx", rk_idx0, n + 1);
            check("emit0_rk", rk0, exp_ks[n+1]);
            check("emit0_done_low", done0, 0);
            n++;
            @(negedge clk);
        end
        check("emit0_beats", n, 10);
        check("emit0_done", done0, 1);
        check("emit0_last_key", last_key0, A1_RK10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
